// File: rtl/dac_phase_sequencer_pkg.sv
// Shared types for the DAC phase sequencer: FSM states, run modes
// and the run-mode decoder.
package dac_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_CONT   = 2'd0,
    M_SINGLE = 2'd1,
    M_TRIG   = 2'd2
  } mode_t;

  // Code 3 is reserved and behaves as continuous.
  function automatic mode_t decode_mode(input logic [1:0] m);
    mode_t r;
    case (m)
      2'd1:    r = M_SINGLE;
      2'd2:    r = M_TRIG;
      default: r = M_CONT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dac_phase_sequencer_counter.sv
// Phase duration down-counter; tc is high during the last cycle
// of a phase. A load of 0 is treated as a load of 1.
module phase_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? W'(1) : load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/dac_phase_sequencer.sv
// Multi-phase DAC pattern generator: per-phase duration and A/B
// levels, continuous, single-shot or triggered sequencing.
module dac_phase_sequencer
  import dac_phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int DAC_WIDTH  = 14,
  parameter int IDLE_LEVEL = 0,
  localparam int PW = $clog2(NUM_PHASES)
) (
  input  logic                 ADC_CLK,
  input  logic                 rst_n,
  input  logic                 run_en,
  input  logic [1:0]           mode,
  input  logic                 TRIG_IN,
  input  logic [PW-1:0]        num_active,
  input  logic                 cfg_we,
  input  logic [PW-1:0]        cfg_phase,
  input  logic                 cfg_sel,
  input  logic [CNT_WIDTH-1:0] cfg_data,
  output logic [DAC_WIDTH-1:0] DAC_A_OUT,
  output logic [DAC_WIDTH-1:0] DAC_B_OUT,
  output logic [PW-1:0]        phase_idx,
  output logic                 phase_stb,
  output logic                 busy,
  output logic                 done
);

  localparam logic [DAC_WIDTH-1:0] IDLE_LVL =
    DAC_WIDTH'(IDLE_LEVEL);
  localparam logic [PW:0]   NP_W = (PW+1)'(NUM_PHASES);
  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);

  logic [CNT_WIDTH-1:0] dur_q   [NUM_PHASES];
  logic [DAC_WIDTH-1:0] lvl_a_q [NUM_PHASES];
  logic [DAC_WIDTH-1:0] lvl_b_q [NUM_PHASES];

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [PW-1:0]        na_q, na_d;
  logic [DAC_WIDTH-1:0] dac_a_q, dac_a_d;
  logic [DAC_WIDTH-1:0] dac_b_q, dac_b_d;
  logic                 stb_q, stb_d;
  logic                 done_q, done_d;
  logic                 trig_prev_q;

  logic          trig_rise;
  logic          enter;
  logic [PW-1:0] enter_ph;
  logic [PW-1:0] na_clamp;
  logic          last;
  logic          cfg_ok;
  logic          cnt_en;
  logic          cnt_tc;

  assign trig_rise = TRIG_IN && !trig_prev_q;
  assign na_clamp  = ({1'b0, num_active} >= NP_W) ?
                     LAST : num_active;
  assign last      = (phase_q >= na_q);
  assign cfg_ok    = ({1'b0, cfg_phase} < NP_W);

  phase_down_counter #(
    .W(CNT_WIDTH)
  ) u_cnt (
    .clk      (ADC_CLK),
    .rst_n    (rst_n),
    .load     (enter),
    .load_val (dur_q[enter_ph]),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    phase_d  = phase_q;
    na_d     = na_q;
    dac_a_d  = dac_a_q;
    dac_b_d  = dac_b_q;
    stb_d    = 1'b0;
    done_d   = 1'b0;
    enter    = 1'b0;
    enter_ph = '0;
    cnt_en   = 1'b0;
    if (!run_en) begin
      state_d = S_IDLE;
      phase_d = '0;
      dac_a_d = IDLE_LVL;
      dac_b_d = IDLE_LVL;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          mode_d = decode_mode(mode);
          if (mode_d == M_TRIG) begin
            state_d = S_ARMED;
          end else begin
            enter = 1'b1;
          end
        end
        S_ARMED: begin
          if (trig_rise) begin
            enter = 1'b1;
          end
        end
        S_RUN: begin
          cnt_en = 1'b1;
          if (cnt_tc && !last) begin
            enter    = 1'b1;
            enter_ph = phase_q + PW'(1);
          end else if (cnt_tc) begin
            unique case (1'b1)
              (mode_q == M_SINGLE): begin
                state_d = S_HOLD;
                done_d  = 1'b1;
                phase_d = '0;
                dac_a_d = IDLE_LVL;
                dac_b_d = IDLE_LVL;
              end
              (mode_q == M_TRIG): begin
                state_d = S_ARMED;
                done_d  = 1'b1;
                phase_d = '0;
                dac_a_d = IDLE_LVL;
                dac_b_d = IDLE_LVL;
              end
              default: enter = 1'b1;
            endcase
          end
        end
        S_HOLD:  state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
      // Table reads use pre-write contents on a same-edge cfg write.
      if (enter) begin
        state_d = S_RUN;
        phase_d = enter_ph;
        dac_a_d = lvl_a_q[enter_ph];
        dac_b_d = lvl_b_q[enter_ph];
        na_d    = na_clamp;
        stb_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= M_CONT;
      phase_q     <= '0;
      na_q        <= '0;
      dac_a_q     <= IDLE_LVL;
      dac_b_q     <= IDLE_LVL;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      na_q        <= na_d;
      dac_a_q     <= dac_a_d;
      dac_b_q     <= dac_b_d;
      stb_q       <= stb_d;
      done_q      <= done_d;
      trig_prev_q <= TRIG_IN;
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        dur_q[i]   <= CNT_WIDTH'(1);
        lvl_a_q[i] <= IDLE_LVL;
        lvl_b_q[i] <= IDLE_LVL;
      end
    end else if (cfg_we && cfg_ok) begin
      if (cfg_sel) begin
        lvl_a_q[cfg_phase] <=
          cfg_data[2*DAC_WIDTH-1 -: DAC_WIDTH];
        lvl_b_q[cfg_phase] <= cfg_data[DAC_WIDTH-1:0];
      end else begin
        dur_q[cfg_phase] <= cfg_data;
      end
    end
  end

  assign DAC_A_OUT = dac_a_q;
  assign DAC_B_OUT = dac_b_q;
  assign phase_idx = phase_q;
  assign phase_stb = stb_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_dac_phase_sequencer.sv
// Scoreboard bench: a cycle-time reference model predicts output
// events; a negedge monitor pops and compares them.
module tb_dac_phase_sequencer;

  localparam int NP = 4;
  localparam int CW = 32;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst_n, run_en, TRIG_IN;
  logic [1:0]    mode, num_active, cfg_phase;
  logic          cfg_we, cfg_sel;
  logic [CW-1:0] cfg_data;
  logic [DW-1:0] DAC_A_OUT, DAC_B_OUT;
  logic [1:0]    phase_idx;
  logic          phase_stb, busy, done;

  always #5 clk = ~clk;

  dac_phase_sequencer #(
    .NUM_PHASES(NP), .CNT_WIDTH(CW),
    .DAC_WIDTH(DW), .IDLE_LEVEL(0)
  ) dut (
    .ADC_CLK(clk), .rst_n(rst_n), .run_en(run_en),
    .mode(mode), .TRIG_IN(TRIG_IN),
    .num_active(num_active), .cfg_we(cfg_we),
    .cfg_phase(cfg_phase), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .DAC_A_OUT(DAC_A_OUT),
    .DAC_B_OUT(DAC_B_OUT), .phase_idx(phase_idx),
    .phase_stb(phase_stb), .busy(busy), .done(done)
  );

  typedef struct {
    int          cyc;
    bit          stb;
    bit          done;
    bit          busy;
    int          idx;
    logic [13:0] a;
    logic [13:0] b;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc++;

  // stimulus drive values
  bit          g_rst, g_run, g_trig, g_we, g_sel;
  int          g_mode, g_na, g_ph;
  logic [31:0] g_data;

  // reference model: 0 idle, 1 armed, 2 run, 3 hold
  int          m_st, m_mode, m_idx, m_na, m_end;
  bit          m_busy, m_tp;
  logic [13:0] m_a, m_b;
  int          t_dur [NP];
  logic [13:0] t_a [NP];
  logic [13:0] t_b [NP];

  task automatic go_idle();
    m_idx = 0;
    m_a   = '0;
    m_b   = '0;
  endtask

  task automatic model_step();
    int e, p;
    bit stb, dn, was;
    e   = cyc + 1;
    stb = 0;
    dn  = 0;
    was = m_busy;
    p   = -1;
    if (!g_rst) begin
      for (int i = 0; i < NP; i++) begin
        t_dur[i] = 1;
        t_a[i]   = '0;
        t_b[i]   = '0;
      end
      m_st = 0;
      m_tp = 0;
      go_idle();
    end else begin
      if (!g_run) begin
        m_st = 0;
        go_idle();
      end else begin
        case (m_st)
          0: begin
            m_mode = (g_mode == 3) ? 0 : g_mode;
            if (m_mode == 2) m_st = 1;
            else p = 0;
          end
          1: if (g_trig && !m_tp) p = 0;
          2: if (e == m_end) begin
            if (m_idx < m_na) p = m_idx + 1;
            else if (m_mode == 0) p = 0;
            else begin
              dn   = 1;
              m_st = (m_mode == 1) ? 3 : 1;
              go_idle();
            end
          end
          default: ;
        endcase
      end
      if (p >= 0) begin
        m_st  = 2;
        m_idx = p;
        m_a   = t_a[p];
        m_b   = t_b[p];
        m_end = e + ((t_dur[p] == 0) ? 1 : t_dur[p]);
        m_na  = (g_na > NP - 1) ? NP - 1 : g_na;
        stb   = 1;
      end
      if (g_we && g_ph < NP) begin
        if (g_sel) begin
          t_a[g_ph] = g_data[27:14];
          t_b[g_ph] = g_data[13:0];
        end else begin
          t_dur[g_ph] = int'(g_data);
        end
      end
      m_tp = g_trig;
    end
    m_busy = (m_st == 2);
    if (stb || dn || (was && !m_busy))
      q.push_back('{e, stb, dn, m_busy, m_idx, m_a, m_b});
  endtask

  task automatic tick(bit we = 0, int ph = 0, bit sel = 0,
                      logic [31:0] data = 0);
    @(negedge clk);
    g_we = we; g_ph = ph; g_sel = sel; g_data = data;
    rst_n      = g_rst;
    run_en     = g_run;
    mode       = 2'(g_mode);
    TRIG_IN    = g_trig;
    num_active = 2'(g_na);
    cfg_we     = we;
    cfg_phase  = 2'(ph);
    cfg_sel    = sel;
    cfg_data   = data;
    model_step();
  endtask

  task automatic wr_lvl(int ph, logic [13:0] a, logic [13:0] b);
    tick(1, ph, 1, {4'b0, a, b});
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // monitor
  bit          mon_on = 0, mon_init = 0;
  logic [13:0] p_a, p_b;
  logic [1:0]  p_idx;
  logic        p_busy;
  ev_t         x;

  always @(negedge clk) begin
    if (mon_on) begin
      if (mon_init) begin
        checks++;
        if (phase_stb === 1'b1 || done === 1'b1 ||
            (p_busy && busy === 1'b0)) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected cyc=%0d stb=%0b done=%0b busy=%0b",
                     cyc, phase_stb, done, busy);
          end else begin
            x = q.pop_front();
            if (x.cyc != cyc || x.stb !== phase_stb ||
                x.done !== done || x.busy !== busy ||
                x.idx != int'(phase_idx) ||
                x.a !== DAC_A_OUT || x.b !== DAC_B_OUT) begin
              errors++;
              $display("FAIL event: got cyc=%0d stb=%0b done=%0b busy=%0b idx=%0d a=%0h b=%0h want cyc=%0d stb=%0b done=%0b busy=%0b idx=%0d a=%0h b=%0h",
                       cyc, phase_stb, done, busy, phase_idx,
                       DAC_A_OUT, DAC_B_OUT, x.cyc, x.stb,
                       x.done, x.busy, x.idx, x.a, x.b);
            end
          end
        end else if (DAC_A_OUT !== p_a || DAC_B_OUT !== p_b ||
                     phase_idx !== p_idx || busy !== p_busy ||
                     phase_stb !== 1'b0 || done !== 1'b0 ||
                     (!busy && (DAC_A_OUT !== 0 ||
                      DAC_B_OUT !== 0 || phase_idx !== 0))) begin
          errors++;
          $display("FAIL hold: cyc=%0d got a=%0h b=%0h idx=%0d busy=%0b want a=%0h b=%0h idx=%0d busy=%0b",
                   cyc, DAC_A_OUT, DAC_B_OUT, phase_idx, busy,
                   p_a, p_b, p_idx, p_busy);
        end
      end
      mon_init = 1;
      p_a    = DAC_A_OUT;
      p_b    = DAC_B_OUT;
      p_idx  = phase_idx;
      p_busy = busy;
    end
  end

  initial begin
    g_rst = 0; g_run = 0; g_trig = 0;
    g_mode = 0; g_na = 3;
    m_busy = 0; m_st = 0; m_mode = 0; m_na = 0; m_end = 0;
    repeat (3) tick();
    g_rst = 1;
    tick();
    @(posedge clk);
    #1;
    chk("rst_a", int'(DAC_A_OUT), 0);
    chk("rst_b", int'(DAC_B_OUT), 0);
    chk("rst_idx", int'(phase_idx), 0);
    chk("rst_stb", int'(phase_stb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    mon_on = 1;

    // default table, continuous
    g_run = 1;
    repeat (12) tick();
    g_run = 0;
    tick();

    // programmed table, continuous
    tick(1, 0, 0, 5);
    tick(1, 1, 0, 3);
    tick(1, 2, 0, 0);
    tick(1, 3, 0, 2);
    wr_lvl(0, 14'h1FFF, 14'h2000);
    wr_lvl(1, 14'h0000, 14'h0000);
    wr_lvl(2, 14'h2000, 14'h1FFF);
    wr_lvl(3, 14'd100, 14'h3F9C);
    g_run = 1;
    repeat (30) tick();

    // single shot, two phases, rerun
    g_run = 0; tick();
    g_mode = 1; g_na = 1; g_run = 1;
    repeat (15) tick();
    g_run = 0; tick();
    g_run = 1;
    repeat (15) tick();
    g_run = 0; tick();

    // triggered
    g_mode = 2; g_na = 3; g_run = 1;
    repeat (5) tick();
    g_trig = 1; tick();
    g_trig = 0; repeat (3) tick();
    g_trig = 1; tick();
    g_trig = 0; repeat (15) tick();
    g_trig = 1; repeat (20) tick();
    g_trig = 0; tick();
    g_trig = 1; repeat (15) tick();
    g_trig = 0;

    // stop mid-run, reset mid-run
    g_mode = 0; g_run = 0; tick();
    g_run = 1; repeat (9) tick();
    g_run = 0; tick();
    g_run = 1; repeat (6) tick();
    g_rst = 0; tick();
    g_rst = 1; repeat (6) tick();

    // rewrite phase-1 duration while phase 1 is active
    g_run = 0; tick();
    tick(1, 0, 0, 2);
    tick(1, 1, 0, 4);
    g_run = 1;
    for (int i = 0; i < 50 && !(m_st == 2 && m_idx == 1); i++)
      tick();
    tick(1, 1, 0, 7);
    repeat (30) tick();

    // random soak
    for (int i = 0; i < 3000; i++) begin
      g_rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) g_run = !g_run;
      if ($urandom_range(0, 3) == 0) g_trig = !g_trig;
      if ($urandom_range(0, 49) == 0)
        g_mode = $urandom_range(0, 3);
      if ($urandom_range(0, 49) == 0)
        g_na = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0)
          tick(1, $urandom_range(0, 3), 0,
               $urandom_range(0, 6));
        else
          tick(1, $urandom_range(0, 3), 1,
               {4'b0, 28'($urandom)});
      end else begin
        tick();
      end
    end

    g_rst = 1; g_run = 0;
    repeat (5) tick();
    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
